bitstream_decoder: RTL and testbench

- Sink-side converter for the stochastic bitstream network. It turns one unipolar output bitstream back into a binary count of ones over a compute window of LENGTH cycles.
- Sits after each network output neuron. It replaces the ad-hoc ones-counting at the network boundary and hands the count to a downstream reader (logger or next stage) through a valid/ready handshake.
- Window framing uses the same compute strobe that drives the upstream number generators.

---
 rtl/bitstream_pkg.sv | 7 +
 rtl/bitstream_decoder_sat_counter.sv | 19 +
 rtl/bitstream_decoder.sv | 67 ++++++
 tb/tb_bitstream_decoder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bitstream_pkg.sv
// bitstream_pkg: shared types and defaults for the bitstream decoder
package bitstream_pkg;
   localparam int BITSTREAM_LENGTH = 256;
   localparam int BITSTREAM_CW = $clog2(BITSTREAM_LENGTH + 1);
   typedef enum logic {DEC_IDLE, DEC_COUNT} dec_state_t;
   typedef logic [BITSTREAM_CW-1:0] count_t;
endpackage

// File: rtl/bitstream_decoder_sat_counter.sv
// sat_counter: up-counter that stops at MAX, with synchronous clear
module sat_counter #(
   parameter int W   = 9,
   parameter int MAX = 256
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         clr,
   input  logic         en,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   // clear wins; otherwise add inc while below MAX so the count never wraps
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && cnt < W'(MAX)) cnt <= cnt + W'(inc);
   end
endmodule

// File: rtl/bitstream_decoder.sv
// bitstream_decoder: counts ones of a unipolar bitstream per compute window
// and hands the count downstream over valid/ready.
// Optional signed output result_bipolar under BITSTREAM_DECODER_BIPOLAR_EN.
module bitstream_decoder
   import bitstream_pkg::*;
#(
   parameter int LENGTH = BITSTREAM_LENGTH,
   parameter int CW     = $clog2(LENGTH + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          compute,
   input  logic          bit_in,
   output logic [CW-1:0] result,
   output logic [CW-1:0] window_len,
   output logic          result_valid,
   input  logic          result_ready,
   output logic          overrun
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
   ,output logic signed [CW:0] result_bipolar
`endif
);
   dec_state_t    state;
   logic [CW-1:0] ones;
   logic [CW-1:0] cyc;
   logic          win_end;

   // counters are already zero in idle, so clearing whenever compute is low
   // both ends a window and lets the first high edge count its bit
   sat_counter #(.W(CW), .MAX(LENGTH)) u_ones (
      .clk(clk), .n_rst(n_rst), .clr(!compute), .en(compute), .inc(bit_in), .cnt(ones)
   );

   sat_counter #(.W(CW), .MAX(LENGTH)) u_cyc (
      .clk(clk), .n_rst(n_rst), .clr(!compute), .en(compute), .inc(1'b1), .cnt(cyc)
   );

   assign win_end = (state == DEC_COUNT) && !compute;

   // window framing, result latch, handshake and sticky overrun
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= DEC_IDLE;
         result       <= '0;
         window_len   <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
         result_bipolar <= '0;
`endif
      end else begin
         state <= compute ? DEC_COUNT : DEC_IDLE;
         if (win_end) begin
            result       <= ones;
            window_len   <= cyc;
            result_valid <= 1'b1;
            if (result_valid && !result_ready) overrun <= 1'b1;
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
            // modular CW+1 arithmetic: the 2*ones term may wrap but the difference fits
            result_bipolar <= $signed({ones, 1'b0}) - $signed({1'b0, cyc});
`endif
         end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_bitstream_decoder.sv
// tb_bitstream_decoder: directed table vectors plus handshake/reset sequences
module tb_bitstream_decoder;
   localparam int LENGTH = 256;
   localparam int CW = $clog2(LENGTH + 1);

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          compute = 1'b0;
   logic          bit_in = 1'b0;
   logic          result_ready = 1'b1;
   logic [CW-1:0] result;
   logic [CW-1:0] window_len;
   logic          result_valid;
   logic          overrun;
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
   logic signed [CW:0] result_bipolar;
`endif

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      int len;
      int ones;
      int exp_res;
      int exp_wlen;
      int exp_bip;
   } vec_t;

   vec_t vecs[7];

   bitstream_decoder #(.LENGTH(LENGTH)) dut (
      .clk(clk),
      .n_rst(n_rst),
      .compute(compute),
      .bit_in(bit_in),
      .result(result),
      .window_len(window_len),
      .result_valid(result_valid),
      .result_ready(result_ready),
      .overrun(overrun)
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
      ,.result_bipolar(result_bipolar)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // k ones spread evenly over n cycles; returns with compute just driven low
   task automatic run_window(input int n, input int k);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         compute = 1'b1;
         bit_in = (((i + 1) * k) / n) != ((i * k) / n);
      end
      @(negedge clk);
      compute = 1'b0;
      bit_in = 1'b0;
   endtask

   initial begin
      vecs[0] = '{256, 107, 107, 256, -42};
      vecs[1] = '{256, 256, 256, 256, 256};
      vecs[2] = '{256, 0, 0, 256, -256};
      vecs[3] = '{300, 300, 256, 256, 256};
      vecs[4] = '{1, 1, 1, 1, 1};
      vecs[5] = '{10, 3, 3, 10, -4};
      vecs[6] = '{100, 100, 100, 100, 100};

      repeat (10) @(negedge clk);
      chk("reset_result", int'(result), 0);
      chk("reset_wlen", int'(window_len), 0);
      chk("reset_valid", int'(result_valid), 0);
      chk("reset_overrun", int'(overrun), 0);
      n_rst = 1'b1;

      for (int v = 0; v < 7; v++) begin
         run_window(vecs[v].len, vecs[v].ones);
         @(negedge clk);
         chk($sformatf("v%0d_valid", v), int'(result_valid), 1);
         chk($sformatf("v%0d_result", v), int'(result), vecs[v].exp_res);
         chk($sformatf("v%0d_wlen", v), int'(window_len), vecs[v].exp_wlen);
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
         chk($sformatf("v%0d_bipolar", v), int'(result_bipolar), vecs[v].exp_bip);
`endif
         @(negedge clk);
         chk($sformatf("v%0d_valid_drop", v), int'(result_valid), 0);
         chk($sformatf("v%0d_overrun", v), int'(overrun), 0);
      end

      result_ready = 1'b0;
      run_window(50, 50);
      @(negedge clk);
      chk("pulse_a_result", int'(result), 50);
      chk("pulse_a_valid", int'(result_valid), 1);
      run_window(200, 200);
      result_ready = 1'b1;
      @(negedge clk);
      chk("pulse_b_result", int'(result), 200);
      chk("pulse_b_wlen", int'(window_len), 200);
      chk("pulse_b_valid", int'(result_valid), 1);
      chk("pulse_b_overrun", int'(overrun), 0);
      @(negedge clk);
      chk("pulse_b_drop", int'(result_valid), 0);

      result_ready = 1'b0;
      run_window(50, 50);
      run_window(200, 200);
      @(negedge clk);
      chk("ovr_result", int'(result), 200);
      chk("ovr_valid", int'(result_valid), 1);
      chk("ovr_overrun", int'(overrun), 1);
      result_ready = 1'b1;
      @(negedge clk);
      chk("ovr_drop", int'(result_valid), 0);
      chk("ovr_sticky", int'(overrun), 1);

      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         compute = 1'b1;
         bit_in = 1'b1;
      end
      @(negedge clk);
      n_rst = 1'b0;
      compute = 1'b0;
      bit_in = 1'b0;
      #1;
      chk("midrst_valid", int'(result_valid), 0);
      chk("midrst_overrun", int'(overrun), 0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      chk("midrst_idle_valid", int'(result_valid), 0);
      run_window(256, 64);
      chk("midrst_pre_end_valid", int'(result_valid), 0);
      @(negedge clk);
      chk("midrst_valid_end", int'(result_valid), 1);
      chk("midrst_result", int'(result), 64);
      chk("midrst_wlen", int'(window_len), 256);
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
      chk("midrst_bipolar", int'(result_bipolar), -128);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
